// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the neural-network phase controller.
//   nn_state_e : sequencer state encoding (IDLE/FWD/BWD/DONE)
//   BITS       : Q8.8 datapath width shared with the neuron blocks
//   max_u      : elaboration-time maximum of two unsigned values
package nn_ctrl_pkg;

  localparam int unsigned BITS = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StBwd,
    StDone
  } nn_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nn_phase_timer.sv
// Loadable down-counter timing how long one layer's enable is held.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (asserted on every layer entry)
//   load_val   : cycles-1 to hold the current enable
//   en         : counting enabled (sequencer is in a phase state)
//   expire     : one-cycle pulse during the last cycle of the phase
module nn_phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expire = en && (count_q == '0);

endmodule

// File: rtl/nn_phase_sequencer.sv
// Sequences forward/backward enables across LAYERS layers, SAMPLES samples and a
// run-time number of epochs. Train runs FWD 0..L-1 then BWD L-1..0 per sample;
// validate runs FWD only, one pass over all samples.
//   clk, rst_n      : clock, async active-low reset
//   tr, vl          : start training / validation (sampled in IDLE, tr wins)
//   abort           : terminate the current run without a done pulse
//   n_epochs        : training epochs, latched at start, 0 treated as 1
//   fp, bp          : one-hot forward / backward layer enables
//   sample, epoch   : current sample and epoch indices
//   mode_tr         : training run active
//   busy            : a phase enable is active
//   done            : one-cycle pulse at normal completion
module nn_phase_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int unsigned LAYERS  = 2,
  parameter int unsigned FP_CYC  = 4,
  parameter int unsigned BP_CYC  = 4,
  parameter int unsigned SAMPLES = 4,
  parameter int unsigned EPOCH_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tr,
  input  logic                       vl,
  input  logic                       abort,
  input  logic [EPOCH_W-1:0]         n_epochs,
  output logic [LAYERS-1:0]          fp,
  output logic [LAYERS-1:0]          bp,
  output logic [$clog2(SAMPLES):0]   sample,
  output logic [EPOCH_W-1:0]         epoch,
  output logic                       mode_tr,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned TW = $clog2(max_u(FP_CYC, BP_CYC)) + 1;
  localparam int unsigned LW = $clog2(LAYERS) + 1;
  localparam int unsigned SW = $clog2(SAMPLES) + 1;

  localparam logic [TW-1:0]     FpLoad     = TW'(FP_CYC - 1);
  localparam logic [TW-1:0]     BpLoad     = TW'(BP_CYC - 1);
  localparam logic [LW-1:0]     LastLayer  = LW'(LAYERS - 1);
  localparam logic [SW-1:0]     LastSample = SW'(SAMPLES - 1);
  localparam logic [LAYERS-1:0] OneHot0    = LAYERS'(1);

  nn_state_e          state_q, state_d;
  logic [LW-1:0]      layer_q, layer_d;
  logic [SW-1:0]      sample_q, sample_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [EPOCH_W-1:0] last_q, last_d;   // final epoch index of this run
  logic               mode_q, mode_d;

  logic          load, expire, adv, in_phase;
  logic [TW-1:0] load_val;

  assign in_phase = (state_q == StFwd) || (state_q == StBwd);

  nn_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .en       (in_phase),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      layer_q  <= '0;
      sample_q <= '0;
      epoch_q  <= '0;
      last_q   <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      sample_q <= sample_d;
      epoch_q  <= epoch_d;
      last_q   <= last_d;
      mode_q   <= mode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    sample_d = sample_q;
    epoch_d  = epoch_q;
    last_d   = last_q;
    mode_d   = mode_q;
    load     = 1'b0;
    load_val = FpLoad;
    adv      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tr || vl) begin
          state_d  = StFwd;
          mode_d   = tr;
          layer_d  = '0;
          sample_d = '0;
          epoch_d  = '0;
          last_d   = (n_epochs == '0) ? '0 : n_epochs - EPOCH_W'(1);
          load     = 1'b1;
        end
      end
      StFwd, StBwd: begin
        if (abort) begin
          state_d  = StIdle;
          layer_d  = '0;
          sample_d = '0;
          epoch_d  = '0;
          mode_d   = 1'b0;
        end else if (expire) begin
          if (state_q == StFwd) begin
            if (layer_q != LastLayer) begin
              layer_d = layer_q + LW'(1);
              load    = 1'b1;
            end else if (mode_q) begin
              // Backward pass starts at the layer the forward pass ended on.
              state_d  = StBwd;
              load     = 1'b1;
              load_val = BpLoad;
            end else begin
              adv = 1'b1;
            end
          end else begin
            if (layer_q != '0) begin
              layer_d  = layer_q - LW'(1);
              load     = 1'b1;
              load_val = BpLoad;
            end else begin
              adv = 1'b1;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Sample/epoch advance; sample and epoch are left at their final values on DONE.
    if (adv) begin
      layer_d = '0;
      if (sample_q != LastSample) begin
        sample_d = sample_q + SW'(1);
        state_d  = StFwd;
        load     = 1'b1;
      end else if (mode_q && (epoch_q != last_q)) begin
        sample_d = '0;
        epoch_d  = epoch_q + EPOCH_W'(1);
        state_d  = StFwd;
        load     = 1'b1;
      end else begin
        state_d = StDone;
        mode_d  = 1'b0;
      end
    end
  end

  always_comb begin
    fp = '0;
    bp = '0;
    if (state_q == StFwd) fp = OneHot0 << layer_q;
    if (state_q == StBwd) bp = OneHot0 << layer_q;
  end

  assign sample  = sample_q;
  assign epoch   = epoch_q;
  assign mode_tr = mode_q && in_phase;
  assign busy    = in_phase;
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_nn_phase_sequencer.sv
module tb_nn_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tr, vl, abort;
  logic [7:0] n_epochs;
  logic [1:0] fp, bp, sample;
  logic [7:0] epoch;
  logic       mode_tr, busy, done;

  int errors = 0;
  int checks = 0;

  // {fp, bp, busy, mode_tr, done, sample, epoch}
  logic [16:0] obs;
  assign obs = {fp, bp, busy, mode_tr, done, sample, epoch};

  nn_phase_sequencer #(
    .LAYERS  (2),
    .FP_CYC  (3),
    .BP_CYC  (2),
    .SAMPLES (2),
    .EPOCH_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tr       (tr),
    .vl       (vl),
    .abort    (abort),
    .n_epochs (n_epochs),
    .fp       (fp),
    .bp       (bp),
    .sample   (sample),
    .epoch    (epoch),
    .mode_tr  (mode_tr),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Per-cycle structural invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(fp | bp) || ((fp & bp) != 2'b00) || (busy !== ((fp | bp) != 2'b00))) begin
        errors++;
        $display("FAIL invariant t=%0t fp=%b bp=%b busy=%b", $time, fp, bp, busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output vector at cycle c (1-based after the start edge).
  function automatic logic [16:0] exp_vec(input int c, input bit trn, input int epochs);
    int per, total, idx, s, e;
    logic [1:0] f, b;
    per   = trn ? 10 : 6;
    total = trn ? epochs * 20 : 12;
    if (c > total) begin
      e = trn ? epochs - 1 : 0;
      return {4'b0000, 1'b0, 1'b0, (c == total + 1), 2'd1, 8'(e)};
    end
    idx = (c - 1) % per;
    s   = ((c - 1) / per) % 2;
    e   = (c - 1) / (per * 2);
    f   = 2'b00;
    b   = 2'b00;
    if (idx < 3)      f = 2'b01;
    else if (idx < 6) f = 2'b10;
    else if (idx < 8) b = 2'b10;
    else              b = 2'b01;
    return {f, b, 1'b1, trn, 1'b0, 2'(s), 8'(e)};
  endfunction

  // Follows a run from cycle 1 through the idle cycle after done. A retrigger of tr and
  // a change of n_epochs are injected at cycle poke (0 = none).
  task automatic follow(input bit trn, input int epochs, input int poke, input string name);
    int total;
    logic [16:0] want;
    total = trn ? epochs * 20 : 12;
    for (int c = 1; c <= total + 2; c++) begin
      want = exp_vec(c, trn, epochs);
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL %s c=%0d got=%h want=%h", name, c, obs, want);
      end
      if (poke != 0 && c == poke) begin
        tr = 1'b1;
        n_epochs = 8'd7;
      end
      if (poke != 0 && c == poke + 1) tr = 1'b0;
      if (c < total + 2) tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tr = 1'b0; vl = 1'b0; abort = 1'b0; n_epochs = 8'd2;
    #12;
    checks++;
    if (obs !== 17'h0) begin
      errors++;
      $display("FAIL reset_hold got=%h want=%h", obs, 17'h0);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== 17'h0) begin
      errors++;
      $display("FAIL reset_idle got=%h want=%h", obs, 17'h0);
    end
  endtask

  task automatic test_train();
    n_epochs = 8'd2;
    tr = 1'b1;
    tick();
    tr = 1'b0;
    follow(1'b1, 2, 0, "train");
  endtask

  task automatic test_validate();
    vl = 1'b1;
    tick();
    vl = 1'b0;
    follow(1'b0, 1, 0, "validate");
  endtask

  task automatic test_priority_retrigger();
    n_epochs = 8'd2;
    tr = 1'b1;
    vl = 1'b1;
    tick();
    tr = 1'b0;
    vl = 1'b0;
    follow(1'b1, 2, 10, "tr_wins_retrigger");
  endtask

  task automatic test_abort();
    n_epochs = 8'd1;
    tr = 1'b1;
    tick();
    tr = 1'b0;
    for (int c = 2; c <= 8; c++) tick();
    checks++;
    if (bp !== 2'b10) begin
      errors++;
      $display("FAIL abort_pre bp=%b want=10", bp);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs !== 17'h0) begin
        errors++;
        $display("FAIL abort_idle k=%0d got=%h want=%h", k, obs, 17'h0);
      end
      tick();
    end
    tr = 1'b1;
    tick();
    tr = 1'b0;
    follow(1'b1, 1, 0, "after_abort");
  endtask

  task automatic test_zero_epochs_and_async_reset();
    n_epochs = 8'd0;
    tr = 1'b1;
    tick();
    tr = 1'b0;
    follow(1'b1, 1, 0, "zero_epochs");
    tr = 1'b1;
    tick();
    tr = 1'b0;
    tick();
    checks++;
    if (fp !== 2'b01) begin
      errors++;
      $display("FAIL async_pre fp=%b want=01", fp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 17'h0) begin
      errors++;
      $display("FAIL async_reset got=%h want=%h", obs, 17'h0);
    end
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 17'h0) begin
      errors++;
      $display("FAIL async_no_resume got=%h want=%h", obs, 17'h0);
    end
  endtask

  initial begin
    test_reset();
    test_train();
    test_validate();
    test_priority_retrigger();
    test_abort();
    test_zero_epochs_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
